// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - branch/jump resolution with warm-up gating, redirect flush and stats
// Optional statistics counters enabled by defining BRANCH_STATS_EN.
module branch_resolve_unit #(
  parameter int WARMUP_CYCLES = 2,
  parameter int FLUSH_DEPTH   = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       f3,
  input  logic             zero,
  input  logic             sign,
  input  logic             borrow,
  input  logic             valid_in,
  input  logic             stall,
  output logic [1:0]       pc_src,
  output logic             redirect,
  output logic             flush,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] branch_cnt
);

  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [1:0] SRC_SEQ    = 2'b00;
  localparam logic [1:0] SRC_PC_IMM = 2'b01;
  localparam logic [1:0] SRC_RS1    = 2'b10;
  localparam logic [3:0] WARM_MAX   = 4'(WARMUP_CYCLES);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH);

  logic [3:0] warm_cnt;
  logic [2:0] flush_cnt;
  logic [1:0] raw_src;
  logic       take_cond;
  logic       warm;
  logic       resolve;

  always_comb begin
    take_cond = 1'b0;
    case (f3)
      3'b000:  take_cond = zero;
      3'b001:  take_cond = !zero;
      3'b100:  take_cond = sign;
      3'b101:  take_cond = !sign;
      3'b110:  take_cond = borrow;
      3'b111:  take_cond = !borrow;
      default: take_cond = 1'b0;
    endcase

    raw_src = SRC_SEQ;
    case (op)
      OP_JAL:    raw_src = SRC_PC_IMM;
      OP_JALR:   raw_src = SRC_RS1;
      OP_BRANCH: raw_src = take_cond ? SRC_PC_IMM : SRC_SEQ;
      default:   raw_src = SRC_SEQ;
    endcase
  end

  assign warm     = (warm_cnt == WARM_MAX);
  assign flush    = (flush_cnt != 3'd0);
  assign resolve  = valid_in && !stall && warm && !flush;
  assign pc_src   = resolve ? raw_src : SRC_SEQ;
  assign redirect = resolve && (raw_src != SRC_SEQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt <= 4'd0;
    end else if (!warm) begin
      warm_cnt <= warm_cnt + 4'd1;
    end
  end

  // Redirects can only occur with flush low, so a reload never collides with a decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= 3'd0;
    end else if (redirect) begin
      flush_cnt <= FLUSH_LOAD;
    end else if (flush && !stall) begin
      flush_cnt <= flush_cnt - 3'd1;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_q;
  logic [CNT_W-1:0] branch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_q  <= '0;
      branch_q <= '0;
    end else begin
      if (redirect && (taken_q != '1)) begin
        taken_q <= taken_q + CNT_W'(1);
      end
      if (resolve && (op == OP_BRANCH) && (branch_q != '1)) begin
        branch_q <= branch_q + CNT_W'(1);
      end
    end
  end

  assign taken_cnt  = taken_q;
  assign branch_cnt = branch_q;
`else
  assign taken_cnt  = '0;
  assign branch_cnt = '0;
`endif

endmodule
